// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time and debounces presses
//   and releases. Each accepted press produces a one-cycle key_valid_o
//   strobe with its hex code on decode_o.
//
//   Optional feature: define KEYPAD_REPEAT_EN to build a held-key repeat
//   counter that re-strobes key_valid_o every REPEAT_CYCLES cycles while
//   the key stays held. With it undefined, each press strobes exactly once.
//
// Parameters
//   SCAN_DIV      clk cycles each column is driven before its rows are sampled
//                 (minimum 3, so the row synchronizer settles within a dwell)
//   DEBOUNCE_CNT  consecutive stable cycles to accept a press or a release
//   REPEAT_CYCLES held-key repeat interval (KEYPAD_REPEAT_EN only, minimum 2)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]   column drive, active-low, exactly one bit low
//   decode_o     code of the most recently accepted key
//   key_valid_o  one-cycle strobe: decode_o is new this cycle
//   key_down_o   high while an accepted key is held (release not yet debounced)
//   state_o      debug view of the scan FSM (0 SCAN, 1 DEBOUNCE, 2 HELD, 3 RELEASE)
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CNT  = 50000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] decode_o,
  output logic       key_valid_o,
  output logic       key_down_o,
  output logic [1:0] state_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 3) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 3");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_CNT must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, rs_q;
  logic [SW-1:0]   div_q, div_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [1:0]      col_sel_q, col_sel_d;
  logic [1:0]      row_sel_q, row_sel_d;
  logic [3:0]      decode_q, decode_d;
  logic            key_valid_q, key_valid_d;
  logic            any_low;
  logic            row_low;
  logic [1:0]      low_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]   rep_q, rep_d;
`endif

  // Row/column position to key code (rows top to bottom, columns left to right).
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index low row wins when several rows in the column are pressed.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) low_idx = 2'(i);
    end
  end

  assign any_low = ~&rs_q;
  assign row_low = ~rs_q[row_sel_q];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    deb_d       = deb_q;
    col_sel_d   = col_sel_q;
    row_sel_d   = row_sel_q;
    decode_d    = decode_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (div_q == SCAN_LAST) begin
          div_d = '0;
          if (any_low) begin
            // col_sel stays put so the pressed column keeps being driven.
            row_sel_d = low_idx;
            deb_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_sel_d = col_sel_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_low) begin
          state_d   = ST_SCAN;
          col_sel_d = col_sel_q + 2'd1;
          div_d     = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d     = ST_HELD;
          decode_d    = map_key(row_sel_q, col_sel_q);
          key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_d       = '0;
`endif
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!row_low) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
        end else if (rep_q == REP_LAST) begin
          key_valid_d = 1'b1;
          rep_d       = '0;
        end else begin
          rep_d = rep_q + 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        // A bounce back to low is the same key still held: no new strobe.
        if (row_low) begin
          state_d = ST_HELD;
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_SCAN;
          col_sel_d = col_sel_q + 2'd1;
          div_d     = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // Synchronizer clears to the released (all-high) level.
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      state_q     <= ST_SCAN;
      div_q       <= '0;
      deb_q       <= '0;
      col_sel_q   <= 2'd0;
      row_sel_q   <= 2'd0;
      decode_q    <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= row_i;
      rs_q        <= sync1_q;
      state_q     <= state_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      col_sel_q   <= col_sel_d;
      row_sel_q   <= row_sel_d;
      decode_q    <= decode_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`endif

  assign col_o       = ~(4'b0001 << col_sel_q);
  assign decode_o    = decode_q;
  assign key_valid_o = key_valid_q;
  // The key counts as down until its release has been debounced.
  assign key_down_o  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8,
//   REPEAT_CYCLES=32. The keypad is modelled physically: a pressed key at
//   (r, c) pulls row r low only while column c is driven low. Expected
//   codes come from a row-major key table; strobes are matched in order
//   against an expected queue.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] decode;
  logic       key_valid;
  logic       key_down;
  logic [1:0] state;

  logic [15:0] pressed;   // bit r*4+c
  logic [3:0]  raw_row;   // direct row override, ANDed with the keypad

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nstrobe = 0;
  logic prev_kv = 1'b0;
  logic [3:0] exp_q[$];
  int strobe_cyc_q[$];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t       vecs[16];
  logic [3:0] kmap[4][4];
  logic [3:0] codes[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .row_i      (row),
    .col_o      (col),
    .decode_o   (decode),
    .key_valid_o(key_valid),
    .key_down_o (key_down),
    .state_o    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Physical keypad: pressed key shorts its row to its column.
  always_comb begin
    row = raw_row;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst) begin
      chk("col_one_low", $countones(~col), 1);
      if (key_valid) begin
        nstrobe++;
        strobe_cyc_q.push_back(cyc);
        chk("no_back_to_back", 32'(prev_kv), 0);
        chk("strobe_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("strobe_decode", decode, exp_q.pop_front());
      end
    end
    prev_kv = key_valid;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int k = 0;
    while (state !== st && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, state, st);
  endtask

  task automatic wait_col_enter(input logic [3:0] target, input int budget, input string name);
    int k = 0;
    while (col === target && k < budget) begin
      @(negedge clk);
      k++;
    end
    while (col !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, col, target);
  endtask

  task automatic wait_strobe(input int budget, input string name);
    int k = 0;
    while (key_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, key_valid, 1);
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int t0;
    int base;
    int mode;
    int r;
    int r2;
    int c;
    int rmin;

    pressed = '0;
    raw_row = 4'hF;
    for (int i = 0; i < 16; i++) begin
      vecs[i].r    = i / 4;
      vecs[i].c    = i % 4;
      vecs[i].code = codes[i];
      kmap[i/4][i%4] = codes[i];
    end

    // Reset state
    tick(3);
    chk("rst_col", col, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_decode", decode, 4'h0);
    chk("rst_key_down", key_down, 0);
    chk("rst_state", state, ST_SCAN);
    rst = 1'b0;

    // Key '6' (row1, col2): one strobe, exact latency, key_down window.
    n0 = nstrobe;
    exp_q.push_back(4'h6);
    press(1, 2);
    wait_state(ST_DEB, 40, "k6_enter_debounce");
    t0 = cyc;
    wait_strobe(20, "k6_strobe");
    chk("k6_latency", 32'(cyc - t0), DEB);
    chk("k6_key_down", key_down, 1);
    tick(20);
    pressed = '0;
    tick(10);
    chk("k6_key_down_in_release", key_down, 1);
    tick(1);
    chk("k6_key_down_low", key_down, 0);
    chk("k6_back_to_scan", state, ST_SCAN);
    chk("k6_next_col", col, 4'b0111);
    tick(30);
    chk("k6_strobe_count", 32'(nstrobe - n0), 1);

    // 3-cycle glitch on row0 during col3: aborted, scanning resumes at col0.
    n0 = nstrobe;
    wait_col_enter(4'b0111, 40, "glitch_col3");
    raw_row = 4'b1110;
    tick(3);
    raw_row = 4'hF;
    tick(1);
    chk("glitch_debounce", state, ST_DEB);
    wait_col_enter(4'b1110, 10, "glitch_resume_col0");
    chk("glitch_scan", state, ST_SCAN);
    tick(30);
    chk("glitch_no_strobe", 32'(nstrobe - n0), 0);

    // Rows 0 and 2 in col3 together: row 0 ('A') wins.
    n0 = nstrobe;
    exp_q.push_back(4'hA);
    press(0, 3);
    press(2, 3);
    tick(32);
    pressed = '0;
    tick(30);
    chk("multi_row_count", 32'(nstrobe - n0), 1);

    // Key 'D' released for 4 cycles then held again: single strobe.
    n0 = nstrobe;
    exp_q.push_back(4'hD);
    press(3, 3);
    wait_strobe(40, "kd_strobe");
    tick(5);
    pressed = '0;
    tick(4);
    chk("kd_in_release", state, ST_REL);
    press(3, 3);
    wait_state(ST_HELD, 8, "kd_back_to_held");
    tick(10);
    chk("kd_still_down", key_down, 1);
    pressed = '0;
    tick(30);
    chk("kd_strobe_count", 32'(nstrobe - n0), 1);

    // Reset 5 cycles into debounce of '5'; key re-detected afterwards.
    n0 = nstrobe;
    press(1, 1);
    wait_state(ST_DEB, 40, "k5_enter_debounce");
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    chk("k5_rst_col", col, 4'b1110);
    chk("k5_rst_state", state, ST_SCAN);
    chk("k5_rst_decode", decode, 4'h0);
    chk("k5_rst_key_down", key_down, 0);
    chk("k5_rst_key_valid", key_valid, 0);
    tick(2);
    rst = 1'b0;
    chk("k5_no_strobe_in_reset", 32'(nstrobe - n0), 0);
    exp_q.push_back(4'h5);
    wait_strobe(60, "k5_strobe_after_rst");
    tick(10);
    pressed = '0;
    tick(30);
    chk("k5_strobe_count", 32'(nstrobe - n0), 1);

    // Key '1' held 100 cycles past its first strobe.
    base = strobe_cyc_q.size();
`ifdef KEYPAD_REPEAT_EN
    repeat (4) exp_q.push_back(4'h1);
`else
    exp_q.push_back(4'h1);
`endif
    press(0, 0);
    wait_strobe(40, "k1_strobe");
    tick(100);
    pressed = '0;
    tick(30);
`ifdef KEYPAD_REPEAT_EN
    chk("k1_repeat_count", 32'(strobe_cyc_q.size() - base), 4);
    if (strobe_cyc_q.size() - base == 4) begin
      for (int i = 1; i < 4; i++)
        chk("k1_repeat_spacing", 32'(strobe_cyc_q[base+i] - strobe_cyc_q[base]), 32'(REP * i));
    end
`else
    chk("k1_single_strobe", 32'(strobe_cyc_q.size() - base), 1);
`endif

    // Table: every key once.
    for (int i = 0; i < 16; i++) begin
      n0 = nstrobe;
      exp_q.push_back(vecs[i].code);
      press(vecs[i].r, vecs[i].c);
      tick(30);
      pressed = '0;
      tick(30);
      chk("tbl_count", 32'(nstrobe - n0), 1);
      chk("tbl_decode_held", decode, vecs[i].code);
      chk("tbl_key_down_low", key_down, 0);
    end

    // Random presses, same-column pairs and short taps.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 4);
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      n0   = nstrobe;
      if (mode == 0) begin
        press(r, c);
        tick($urandom_range(1, 5));
        pressed = '0;
        tick(20);
        chk("rnd_tap_no_strobe", 32'(nstrobe - n0), 0);
      end else begin
        r2   = (mode == 1) ? $urandom_range(0, 3) : r;
        rmin = (r < r2) ? r : r2;
        exp_q.push_back(kmap[rmin][c]);
        press(r, c);
        press(r2, c);
        tick($urandom_range(30, 38));
        pressed = '0;
        tick($urandom_range(14, 30));
        chk("rnd_count", 32'(nstrobe - n0), 1);
      end
    end

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
